// File: rtl/decryption_regfile_mc_if.sv
// Bus between the master and the multi-channel decryption key register file.
// The master drives the request; the register file answers with a registered done/error/rdata.
interface decryption_regfile_mc_if #(
  parameter int addr_width = 8,
  parameter int reg_width  = 16
);
  logic [addr_width-1:0] addr;
  logic                  read;
  logic                  write;
  logic [reg_width-1:0]  wdata;
  logic [reg_width-1:0]  rdata;
  logic                  done;
  logic                  error;

  modport master (
    output addr, read, write, wdata,
    input  rdata, done, error
  );

  modport slave (
    input  addr, read, write, wdata,
    output rdata, done, error
  );
endinterface

// File: rtl/decryption_regfile_mc.sv
// Multi-channel decryption key register file: shadow key registers per channel,
// atomic commit of all shadows to the active outputs, write lock and a 1-cycle response.
module decryption_regfile_mc #(
  parameter int addr_width = 8,
  parameter int reg_width  = 16,
  parameter int NUM_CH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  decryption_regfile_mc_if.slave      bus,
  output logic [NUM_CH*2-1:0]         select,
  output logic [NUM_CH*reg_width-1:0] caesar_key,
  output logic [NUM_CH*reg_width-1:0] scytale_key,
  output logic [NUM_CH*reg_width-1:0] zigzag_key
);

  localparam logic [4:0] OFF_SELECT  = 5'h00;
  localparam logic [4:0] OFF_CAESAR  = 5'h10;
  localparam logic [4:0] OFF_SCYTALE = 5'h12;
  localparam logic [4:0] OFF_ZIGZAG  = 5'h14;
  localparam logic [7:0] ADDR_CTRL   = 8'hF0;
  localparam logic [7:0] ADDR_STATUS = 8'hF2;

  localparam logic [reg_width-1:0] SCYTALE_RST = reg_width'(16'hFFFF);
  localparam logic [reg_width-1:0] ZIGZAG_RST  = reg_width'(2);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t state, state_next;

  logic [1:0]           sh_sel      [NUM_CH];
  logic [reg_width-1:0] sh_caesar   [NUM_CH];
  logic [reg_width-1:0] sh_scytale  [NUM_CH];
  logic [reg_width-1:0] sh_zigzag   [NUM_CH];
  logic [1:0]           act_sel     [NUM_CH];
  logic [reg_width-1:0] act_caesar  [NUM_CH];
  logic [reg_width-1:0] act_scytale [NUM_CH];
  logic [reg_width-1:0] act_zigzag  [NUM_CH];

  logic                 lock;
  logic                 dirty;
  logic [reg_width-1:0] rdata_q;
  logic                 error_q;

  logic [7:0]           addr8;
  logic [2:0]           ch;
  logic [4:0]           off;
  logic [NUM_CH-1:0]    ch_hit;
  logic                 ch_ok;
  logic                 off_ok;
  logic                 is_key;
  logic                 is_ctrl;
  logic                 is_status;
  logic                 req;
  logic                 rd_ok;
  logic                 key_wr;
  logic                 ctrl_wr;
  logic                 err_next;
  logic [reg_width-1:0] key_rdata;
  logic [reg_width-1:0] ctrl_rdata;
  logic [reg_width-1:0] status_rdata;
  logic [reg_width-1:0] rdata_next;

  // Address decode and access classification; anything not explicitly legal is an error.
  always_comb begin
    addr8     = bus.addr[7:0];
    ch        = addr8[7:5];
    off       = addr8[4:0];
    ch_hit    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_hit[k] = (ch == 3'(k));
    end
    ch_ok     = |ch_hit;
    off_ok    = (off == OFF_SELECT) || (off == OFF_CAESAR) ||
                (off == OFF_SCYTALE) || (off == OFF_ZIGZAG);
    is_key    = ch_ok && off_ok;
    is_ctrl   = (addr8 == ADDR_CTRL);
    is_status = (addr8 == ADDR_STATUS);

    req       = bus.read | bus.write;
    rd_ok     = bus.read & ~bus.write & (is_key | is_ctrl | is_status);
    key_wr    = bus.write & ~bus.read & is_key & ~lock;
    ctrl_wr   = bus.write & ~bus.read & is_ctrl;
    err_next  = req & ~(rd_ok | key_wr | ctrl_wr);
  end

  // Read data mux; key reads return the shadow copy, not the active one.
  always_comb begin
    key_rdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_hit[k]) begin
        case (off)
          OFF_SELECT:  key_rdata = {{(reg_width-2){1'b0}}, sh_sel[k]};
          OFF_CAESAR:  key_rdata = sh_caesar[k];
          OFF_SCYTALE: key_rdata = sh_scytale[k];
          OFF_ZIGZAG:  key_rdata = sh_zigzag[k];
          default:     key_rdata = '0;
        endcase
      end
    end

    ctrl_rdata         = '0;
    ctrl_rdata[0]      = lock;
    status_rdata       = '0;
    status_rdata[15:8] = 8'(NUM_CH);
    status_rdata[0]    = dirty;

    rdata_next = '0;
    if (rd_ok) begin
      if (is_key)       rdata_next = key_rdata;
      else if (is_ctrl) rdata_next = ctrl_rdata;
      else              rdata_next = status_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Every accepted request, even in RESP, produces a response in the next cycle.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = req ? RESP : IDLE;
      RESP:    state_next = req ? RESP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register file state: shadow writes, atomic commit, lock/dirty and the response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        sh_sel[k]      <= '0;
        sh_caesar[k]   <= '0;
        sh_scytale[k]  <= SCYTALE_RST;
        sh_zigzag[k]   <= ZIGZAG_RST;
        act_sel[k]     <= '0;
        act_caesar[k]  <= '0;
        act_scytale[k] <= SCYTALE_RST;
        act_zigzag[k]  <= ZIGZAG_RST;
      end
      lock    <= 1'b0;
      dirty   <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      rdata_q <= rdata_next;
      error_q <= err_next;

      if (key_wr) begin
        dirty <= 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
          if (ch_hit[k]) begin
            case (off)
              OFF_SELECT:  sh_sel[k]     <= bus.wdata[1:0];
              OFF_CAESAR:  sh_caesar[k]  <= bus.wdata;
              OFF_SCYTALE: sh_scytale[k] <= bus.wdata;
              OFF_ZIGZAG:  sh_zigzag[k]  <= bus.wdata;
              default:     ;
            endcase
          end
        end
      end

      if (ctrl_wr) begin
        lock <= bus.wdata[0];
        if (bus.wdata[1]) begin
          dirty <= 1'b0;
          for (int k = 0; k < NUM_CH; k++) begin
            act_sel[k]     <= sh_sel[k];
            act_caesar[k]  <= sh_caesar[k];
            act_scytale[k] <= sh_scytale[k];
            act_zigzag[k]  <= sh_zigzag[k];
          end
        end
      end
    end
  end

  always_comb begin
    select      = '0;
    caesar_key  = '0;
    scytale_key = '0;
    zigzag_key  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      select[2*k +: 2]                     = act_sel[k];
      caesar_key[k*reg_width +: reg_width]  = act_caesar[k];
      scytale_key[k*reg_width +: reg_width] = act_scytale[k];
      zigzag_key[k*reg_width +: reg_width]  = act_zigzag[k];
    end
  end

  assign bus.done  = (state == RESP);
  assign bus.rdata = rdata_q;
  assign bus.error = error_q;

endmodule
